// File: rtl/sram2rw_fifo_pkg.sv
// Shared constants and types for the SRAM2RW16x32-backed FIFO controller.
package sram2rw_fifo_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W+1:0] cnt_t;

endpackage

// File: rtl/sram2rw_fifo_outq.sv
// Two-entry ready/valid output queue; head register is held while stalled.
module sram2rw_fifo_outq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_valid_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              deq_valid_o,
  input  logic              deq_ready_i,
  output logic [DATA_W-1:0] deq_data_o,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              pop;

  assign deq_valid_o = (occ_q != 2'd0);
  assign deq_data_o  = head_q;
  assign occ_o       = occ_q;
  assign pop         = deq_valid_o && deq_ready_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push_valid_i, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data_i;
        else               tail_d = push_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/sram2rw_fifo_ctrl.sv
// FIFO controller for an SRAM2RW16x32 macro (port 1 write, port 2 read).
// Optional `SRAM_FIFO_BYPASS_EN: words enqueued into an empty FIFO skip the SRAM.
module sram2rw_fifo_ctrl #(
  parameter int unsigned DATA_W = sram2rw_fifo_pkg::DATA_W,
  parameter int unsigned ADDR_W = sram2rw_fifo_pkg::ADDR_W,
  parameter int unsigned DEPTH  = sram2rw_fifo_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_bits,
  output logic [ADDR_W+1:0] count,
  output logic [ADDR_W-1:0] sram_a1,
  output logic              sram_csb1,
  output logic              sram_web1,
  output logic              sram_oeb1,
  output logic [DATA_W-1:0] sram_i1,
  output logic [ADDR_W-1:0] sram_a2,
  output logic              sram_csb2,
  output logic              sram_web2,
  output logic              sram_oeb2,
  output logic [DATA_W-1:0] sram_i2,
  input  logic [DATA_W-1:0] sram_o2
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   scount_q, scount_d;
  logic              inflight_q, inflight_d;

  logic              enq_fire, wr, bypass, issue, deq_fire, push;
  logic [DATA_W-1:0] push_data;
  logic [1:0]        oq_occ;
  logic [2:0]        credit;

  assign enq_ready = !reset && (scount_q < FULL);
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

`ifdef SRAM_FIFO_BYPASS_EN
  assign bypass = enq_fire && (scount_q == '0) && !inflight_q && (oq_occ != 2'd2);
`else
  assign bypass = 1'b0;
`endif

  assign wr = enq_fire && !bypass;

  // A same-cycle dequeue frees its slot before the issued read returns, which
  // is what lets a 2-entry queue sustain one word per cycle.
  assign credit = 3'(oq_occ) + 3'(inflight_q) - 3'(deq_fire);
  assign issue  = (scount_q != '0) && (credit < 3'd2);

  assign push      = inflight_q || bypass;
  assign push_data = inflight_q ? sram_o2 : enq_bits;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    scount_d   = scount_q;
    inflight_d = issue;
    if (wr)    wptr_d = wptr_q + ADDR_W'(1);
    if (issue) rptr_d = rptr_q + ADDR_W'(1);
    if (wr && !issue)      scount_d = scount_q + ONE;
    else if (!wr && issue) scount_d = scount_q - ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      scount_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      scount_q   <= scount_d;
      inflight_q <= inflight_d;
    end
  end

  sram2rw_fifo_outq #(.DATA_W(DATA_W)) u_outq (
    .clock        (clock),
    .reset        (reset),
    .push_valid_i (push),
    .push_data_i  (push_data),
    .deq_valid_o  (deq_valid),
    .deq_ready_i  (deq_ready),
    .deq_data_o   (deq_bits),
    .occ_o        (oq_occ)
  );

  assign count = (ADDR_W+2)'(scount_q) + (ADDR_W+2)'(inflight_q) + (ADDR_W+2)'(oq_occ);

  assign sram_csb1 = !wr;
  assign sram_a1   = wptr_q;
  assign sram_i1   = wr ? enq_bits : '0;
  assign sram_web1 = 1'b0;
  assign sram_oeb1 = 1'b1;

  assign sram_csb2 = !issue;
  assign sram_a2   = rptr_q;
  assign sram_web2 = 1'b1;
  assign sram_oeb2 = 1'b0;
  assign sram_i2   = '0;

endmodule

// File: tb/tb_sram2rw_fifo_ctrl.sv
// Directed bench for sram2rw_fifo_ctrl with a behavioural SRAM2RW16x32 model.
module tb_sram2rw_fifo_ctrl;
  import sram2rw_fifo_pkg::*;

`ifdef SRAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic  clock = 1'b0;
  logic  reset;
  logic  enq_valid, enq_ready, deq_valid, deq_ready;
  data_t enq_bits, deq_bits;
  cnt_t  count;
  addr_t sram_a1, sram_a2;
  logic  sram_csb1, sram_web1, sram_oeb1, sram_csb2, sram_web2, sram_oeb2;
  data_t sram_i1, sram_i2, sram_o2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sram2rw_fifo_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_bits  (enq_bits),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_bits  (deq_bits),
    .count     (count),
    .sram_a1   (sram_a1),
    .sram_csb1 (sram_csb1),
    .sram_web1 (sram_web1),
    .sram_oeb1 (sram_oeb1),
    .sram_i1   (sram_i1),
    .sram_a2   (sram_a2),
    .sram_csb2 (sram_csb2),
    .sram_web2 (sram_web2),
    .sram_oeb2 (sram_oeb2),
    .sram_i2   (sram_i2),
    .sram_o2   (sram_o2)
  );

  // Macro model: registered read, write on port 1, contents survive reset.
  data_t mem [DEPTH];
  always @(posedge clock) begin
    if (!sram_csb1 && !sram_web1) mem[sram_a1] <= sram_i1;
    if (!sram_csb2 && !sram_oeb2) sram_o2 <= mem[sram_a2];
  end

  typedef struct {
    logic rst, ev; data_t ed; logic dr;
    logic er, dv; data_t db; cnt_t cnt;
    logic csb1; addr_t a1; data_t i1; logic csb2; addr_t a2;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    data_t mq[$];
    data_t held;
    logic  stalled;
    int    sent, got;
    logic  seen;

    reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;
    tick();

    //       rst   ev    ed            dr    er    dv    db            cnt   csb1  a1    i1            csb2  a2
    tbl[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        6'd0, 1'b1, 4'd0, 32'h0,        1'b1, 4'd0};
`ifdef SRAM_FIFO_BYPASS_EN
    tbl[1] = '{1'b0, 1'b1, 32'h0000_00A5, 1'b0, 1'b1, 1'b0, 32'h0,        6'd0, 1'b1, 4'd0, 32'h0,        1'b1, 4'd0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_00A5, 6'd1, 1'b1, 4'd0, 32'h0,        1'b1, 4'd0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        6'd0, 1'b1, 4'd0, 32'h0,        1'b1, 4'd0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        6'd0, 1'b1, 4'd0, 32'h0,        1'b1, 4'd0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        6'd0, 1'b1, 4'd0, 32'h0,        1'b1, 4'd0};
`else
    tbl[1] = '{1'b0, 1'b1, 32'h0000_00A5, 1'b0, 1'b1, 1'b0, 32'h0,        6'd0, 1'b0, 4'd0, 32'h0000_00A5, 1'b1, 4'd0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        6'd1, 1'b1, 4'd1, 32'h0,        1'b0, 4'd0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        6'd1, 1'b1, 4'd1, 32'h0,        1'b1, 4'd1};
    tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_00A5, 6'd1, 1'b1, 4'd1, 32'h0,        1'b1, 4'd1};
    tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        6'd0, 1'b1, 4'd1, 32'h0,        1'b1, 4'd1};
`endif

    for (int i = 0; i < 6; i++) begin
      reset = tbl[i].rst; enq_valid = tbl[i].ev; enq_bits = tbl[i].ed; deq_ready = tbl[i].dr;
      #4;
      chk($sformatf("t%0d_enq_ready", i), enq_ready, tbl[i].er);
      chk($sformatf("t%0d_deq_valid", i), deq_valid, tbl[i].dv);
      if (tbl[i].dv) chk($sformatf("t%0d_deq_bits", i), deq_bits, tbl[i].db);
      chk($sformatf("t%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("t%0d_csb1", i), sram_csb1, tbl[i].csb1);
      chk($sformatf("t%0d_a1", i), sram_a1, tbl[i].a1);
      chk($sformatf("t%0d_i1", i), sram_i1, tbl[i].i1);
      chk($sformatf("t%0d_csb2", i), sram_csb2, tbl[i].csb2);
      chk($sformatf("t%0d_a2", i), sram_a2, tbl[i].a2);
      tick();
    end

    // Fill 18 words with no consumer, probe the full boundary, then drain.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      enq_valid = 1'b1; enq_bits = data_t'(i);
      #4;
      chk($sformatf("fill%0d_enq_ready", i), enq_ready, 1'b1);
      tick();
    end
    enq_bits = 32'd18;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("full_enq_ready", enq_ready, 1'b0);
      chk("full_csb1", sram_csb1, 1'b1);
      chk("full_count", count, 6'd18);
      tick();
    end
    deq_ready = 1'b1;
    #4;
    chk("full_pop_csb1", sram_csb1, 1'b1);
    chk("full_pop_bits", deq_bits, 32'd0);
    tick();
    #4;
    chk("freed_csb1", sram_csb1, 1'b0);
    chk("freed_bits", deq_bits, 32'd1);
    tick();
    enq_valid = 1'b0;
    for (int i = 2; i <= 18; i++) begin
      #4;
      chk($sformatf("drain%0d_valid", i), deq_valid, 1'b1);
      chk($sformatf("drain%0d_bits", i), deq_bits, data_t'(i));
      tick();
    end
    #4;
    chk("drained_valid", deq_valid, 1'b0);
    chk("drained_count", count, 6'd0);
    tick();

    // Streaming: one word in and one out per cycle across pointer wrap.
    do_reset();
    deq_ready = 1'b1;
    for (int c = 0; c < 40 + LAT; c++) begin
      enq_valid = (c < 40);
      enq_bits  = data_t'(200 + c);
      #4;
      if (c < 40) chk($sformatf("stream%0d_enq_ready", c), enq_ready, 1'b1);
      if (c >= LAT) begin
        chk($sformatf("stream%0d_valid", c), deq_valid, 1'b1);
        chk($sformatf("stream%0d_bits", c), deq_bits, data_t'(200 + c - LAT));
      end else begin
        chk($sformatf("stream%0d_valid", c), deq_valid, 1'b0);
      end
      tick();
    end
    #4;
    chk("stream_end_count", count, 6'd0);
    tick();

    // Random backpressure against a reference queue.
    do_reset();
    mq.delete();
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 3000 && got < 200; cyc++) begin
      enq_valid = (sent < 200);
      enq_bits  = 32'h1000_0000 + data_t'(sent);
      deq_ready = 1'($urandom_range(0, 1));
      #4;
      chk("rand_count", count, 64'(mq.size()));
      if (stalled) begin
        chk("rand_hold_valid", deq_valid, 1'b1);
        chk("rand_hold_bits", deq_bits, held);
      end
      if (deq_valid) begin
        if (mq.size() == 0) begin
          chk("rand_spurious_valid", deq_valid, 1'b0);
        end else begin
          chk("rand_bits", deq_bits, mq[0]);
          if (deq_ready) begin
            void'(mq.pop_front());
            got++;
          end
        end
      end
      if (enq_valid && enq_ready) begin
        mq.push_back(enq_bits);
        sent++;
      end
      stalled = deq_valid && !deq_ready;
      held    = deq_bits;
      tick();
    end
    chk("rand_words_out", 64'(got), 64'd200);

    // Reset with 10 words held and a read in flight.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      enq_valid = 1'b1; enq_bits = data_t'(300 + i);
      tick();
    end
    enq_valid = 1'b0;
    tick(); tick(); tick();
    #4;
    chk("rst_pre_count", count, 6'd10);
    tick();
    deq_ready = 1'b1; enq_valid = 1'b1; enq_bits = 32'd400;
    #4;
    chk("rst_pre_bits", deq_bits, 32'd300);
    chk("rst_pre_issue", sram_csb2, 1'b0);
    tick();
    deq_ready = 1'b0; enq_valid = 1'b0;
    #4;
    chk("rst_inflight_count", count, 6'd10);
    reset = 1'b1; enq_valid = 1'b1; enq_bits = 32'hBAD0_BAD0;
    #1;
    chk("rst_enq_ready", enq_ready, 1'b0);
    chk("rst_deq_valid", deq_valid, 1'b0);
    chk("rst_count", count, 6'd0);
    chk("rst_csb1", sram_csb1, 1'b1);
    chk("rst_csb2", sram_csb2, 1'b1);
    chk("rst_a1", sram_a1, 4'd0);
    chk("rst_a2", sram_a2, 4'd0);
    chk("rst_i1", sram_i1, 32'h0);
    tick();
    reset = 1'b0; enq_valid = 1'b0; deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk($sformatf("post_rst%0d_enq_ready", i), enq_ready, 1'b1);
      chk($sformatf("post_rst%0d_valid", i), deq_valid, 1'b0);
      chk($sformatf("post_rst%0d_count", i), count, 6'd0);
      tick();
    end
    enq_valid = 1'b1; enq_bits = 32'hDEAD_BEEF;
    tick();
    enq_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #4;
      if (deq_valid) begin
        seen = 1'b1;
        chk("post_rst_first_bits", deq_bits, 32'hDEAD_BEEF);
      end
      tick();
    end
    chk("post_rst_word_seen", seen, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
